// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load sizes, late-buffer FSM states and the zero register.
package wb_pkg;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FORCE
  } wb_state_e;
endpackage

// File: rtl/writeback_stage_if.sv
// Bundle between MEM stage / late unit (master) and the writeback stage (slave), incl. register-file port.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              mem_valid;
  logic              mem_flush;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic [1:0]        mem_load_size;
  logic              mem_load_unsigned;
  logic [1:0]        mem_byte_off;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;

  logic              late_valid;
  logic              late_ready;
  logic [REG_AW-1:0] late_rd;
  logic [DATA_W-1:0] late_data;

  logic              reg_write_en;
  logic [REG_AW-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_data;
  logic              wb_stall_req;

  modport master (
    output mem_valid, mem_flush, mem_reg_write, mem_mem_to_reg, mem_load_size,
           mem_load_unsigned, mem_byte_off, mem_rd, mem_alu_result, mem_load_data,
           late_valid, late_rd, late_data,
    input  late_ready, reg_write_en, reg_write_dest, reg_write_data,
           fwd_valid, fwd_dest, fwd_data, wb_stall_req
  );

  modport slave (
    input  mem_valid, mem_flush, mem_reg_write, mem_mem_to_reg, mem_load_size,
           mem_load_unsigned, mem_byte_off, mem_rd, mem_alu_result, mem_load_data,
           late_valid, late_rd, late_data,
    output late_ready, reg_write_en, reg_write_dest, reg_write_data,
           fwd_valid, fwd_dest, fwd_data, wb_stall_req
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a little-endian load word and sign/zero-extends it.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = data[{off, 3'b000} +: 8];
    // Halfword lane is chosen by off[1] alone; a misaligned off[0] is ignored.
    h      = data[{off[1], 4'b0000} +: 16];
    result = data;
    case (size)
      LS_BYTE: result = {{(DATA_W-8){~is_unsigned & b[7]}}, b};
      LS_HALF: result = {{(DATA_W-16){~is_unsigned & h[15]}}, h};
      default: result = data;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// MIPS WB stage: registers MEM results, arbitrates the register-file write port with a 1-entry late buffer.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  writeback_stage_if.slave bus
);
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;

  logic              vld_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [DATA_W-1:0] data_p1;

  logic              l_full;
  logic [REG_AW-1:0] l_rd;
  logic [DATA_W-1:0] l_data;
  logic              l_set;
  logic              l_clear;
  logic              sel_late;

  wb_state_e         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              stall_q;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .data        (bus.mem_load_data),
    .size        (bus.mem_load_size),
    .off         (bus.mem_byte_off),
    .is_unsigned (bus.mem_load_unsigned),
    .result      (aligned)
  );

  assign vld_p0  = bus.mem_valid & ~bus.mem_flush & bus.mem_reg_write &
                   (bus.mem_rd != REG_AW'(REG_ZERO));
  assign data_p0 = bus.mem_mem_to_reg ? aligned : bus.mem_alu_result;

  // p0 -> p1: MEM result captured every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      rd_p1   <= bus.mem_rd;
      data_p1 <= data_p0;
    end
  end

  // Pipeline always wins; a same-rd pipeline write supersedes the older late entry.
  assign sel_late = l_full & ~vld_p1;
  assign l_clear  = l_full & (~vld_p1 | (rd_p1 == l_rd));
  assign l_set    = bus.late_valid & ~l_full & (bus.late_rd != REG_AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_full <= 1'b0;
      l_rd   <= '0;
      l_data <= '0;
    end else begin
      l_full <= l_set | (l_full & ~l_clear);
      if (l_set) begin
        l_rd   <= bus.late_rd;
        l_data <= bus.late_data;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (l_set) begin
          state_d = PENDING;
          cnt_d   = '0;
        end
      end
      PENDING: begin
        if (l_clear)                                state_d = IDLE;
        else if (cnt == CNT_W'(STARVE_LIMIT - 1))   state_d = FORCE;
        else                                        cnt_d   = cnt + CNT_W'(1);
      end
      FORCE: begin
        if (l_clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      stall_q <= (state_d == FORCE);
    end
  end

  // p1 -> register file: write port driven from registered state only
  assign bus.reg_write_en   = vld_p1 | sel_late;
  assign bus.reg_write_dest = vld_p1 ? rd_p1   : (sel_late ? l_rd   : '0);
  assign bus.reg_write_data = vld_p1 ? data_p1 : (sel_late ? l_data : '0);
  assign bus.fwd_valid      = bus.reg_write_en;
  assign bus.fwd_dest       = bus.reg_write_dest;
  assign bus.fwd_data       = bus.reg_write_data;
  assign bus.late_ready     = ~l_full;
  assign bus.wb_stall_req   = stall_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load writes, late buffer, starvation stall, WAW drop, reset.
module tb_writeback_stage;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  writeback_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  writeback_stage #(.DATA_W(32), .REG_AW(5), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.mem_valid         = 1'b0;
    bus.mem_flush         = 1'b0;
    bus.mem_reg_write     = 1'b0;
    bus.mem_mem_to_reg    = 1'b0;
    bus.mem_load_size     = LS_WORD;
    bus.mem_load_unsigned = 1'b0;
    bus.mem_byte_off      = 2'b00;
    bus.mem_rd            = '0;
    bus.mem_alu_result    = '0;
    bus.mem_load_data     = '0;
    bus.late_valid        = 1'b0;
    bus.late_rd           = '0;
    bus.late_data         = '0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] d);
    bus.mem_valid      = 1'b1;
    bus.mem_reg_write  = 1'b1;
    bus.mem_mem_to_reg = 1'b0;
    bus.mem_rd         = rd;
    bus.mem_alu_result = d;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [1:0] sz, input logic uns,
                         input logic [1:0] off, input logic [31:0] word);
    bus.mem_valid         = 1'b1;
    bus.mem_reg_write     = 1'b1;
    bus.mem_mem_to_reg    = 1'b1;
    bus.mem_rd            = rd;
    bus.mem_load_size     = sz;
    bus.mem_load_unsigned = uns;
    bus.mem_byte_off      = off;
    bus.mem_load_data     = word;
    bus.mem_alu_result    = 32'hDEAD_BEEF;
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [4:0] rd,
                           input logic [31:0] d);
    check({tag, "_en"},   bus.reg_write_en,   en);
    check({tag, "_dest"}, bus.reg_write_dest, rd);
    check({tag, "_data"}, bus.reg_write_data, d);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_in();
    step();
    step();
    expect_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst_late_ready", bus.late_ready, 1'b1);
    check("rst_stall", bus.wb_stall_req, 1'b0);
    check("rst_fwd_valid", bus.fwd_valid, 1'b0);
    rst_n = 1'b1;
    step();

    // ALU write, exactly one cycle
    alu_op(5'd5, 32'h0000_1234);
    step();
    idle_in();
    expect_wr("alu", 1'b1, 5'd5, 32'h0000_1234);
    check("alu_fwd_valid", bus.fwd_valid, 1'b1);
    check("alu_fwd_dest", bus.fwd_dest, 5'd5);
    check("alu_fwd_data", bus.fwd_data, 32'h0000_1234);
    step();
    check("alu_once_en", bus.reg_write_en, 1'b0);

    // Load alignment and extension
    load_op(5'd3, LS_BYTE, 1'b0, 2'd3, 32'h80FF_0000);
    step();
    expect_wr("lb_off3", 1'b1, 5'd3, 32'hFFFF_FF80);
    load_op(5'd4, LS_HALF, 1'b1, 2'd2, 32'h80FF_0000);
    step();
    expect_wr("lhu_off2", 1'b1, 5'd4, 32'h0000_80FF);
    load_op(5'd6, LS_HALF, 1'b0, 2'd3, 32'h80FF_0000);
    step();
    expect_wr("lh_off3", 1'b1, 5'd6, 32'hFFFF_80FF);
    load_op(5'd8, LS_BYTE, 1'b1, 2'd2, 32'h80FF_0000);
    step();
    expect_wr("lbu_off2", 1'b1, 5'd8, 32'h0000_00FF);
    load_op(5'd11, 2'b11, 1'b0, 2'd1, 32'h8765_4321);
    step();
    expect_wr("lw_sz3", 1'b1, 5'd11, 32'h8765_4321);
    idle_in();
    alu_op(5'd0, 32'h1111_1111);
    step();
    check("rd0_en", bus.reg_write_en, 1'b0);
    alu_op(5'd13, 32'h2222_2222);
    bus.mem_flush = 1'b1;
    step();
    check("flush_en", bus.reg_write_en, 1'b0);
    idle_in();
    step();

    // Late result with idle pipe
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd9;
    bus.late_data  = 32'h0000_AAAA;
    step();
    idle_in();
    check("late_ready_low", bus.late_ready, 1'b0);
    expect_wr("late_wr", 1'b1, 5'd9, 32'h0000_AAAA);
    step();
    check("late_ready_back", bus.late_ready, 1'b1);
    check("late_once_en", bus.reg_write_en, 1'b0);

    // Late rd=0 accepted and dropped
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd0;
    bus.late_data  = 32'h1234_5678;
    step();
    idle_in();
    check("late_rd0_ready", bus.late_ready, 1'b1);
    check("late_rd0_en", bus.reg_write_en, 1'b0);

    // Starvation: late pending behind back-to-back pipeline writes
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd12;
    bus.late_data  = 32'h0000_BEEF;
    alu_op(5'd1, 32'h100);
    step();
    bus.late_valid = 1'b0;
    check("starve_ready", bus.late_ready, 1'b0);
    check("starve_stall_0", bus.wb_stall_req, 1'b0);
    expect_wr("starve_p0", 1'b1, 5'd1, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      alu_op(5'(k + 1), 32'h100 + k);
      step();
      check($sformatf("starve_stall_%0d", k), bus.wb_stall_req, 1'b0);
      check($sformatf("starve_dest_%0d", k), bus.reg_write_dest, 32'(k + 1));
    end
    alu_op(5'd20, 32'h200);
    step();
    check("starve_stall_4", bus.wb_stall_req, 1'b1);
    expect_wr("starve_p4", 1'b1, 5'd20, 32'h200);
    idle_in();
    step();
    expect_wr("starve_drain", 1'b1, 5'd12, 32'h0000_BEEF);
    check("starve_stall_drain", bus.wb_stall_req, 1'b1);
    step();
    check("starve_stall_off", bus.wb_stall_req, 1'b0);
    check("starve_ready_back", bus.late_ready, 1'b1);
    check("starve_idle_en", bus.reg_write_en, 1'b0);

    // WAW: pipeline rd matches pending late rd
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd7;
    bus.late_data  = 32'h0000_0077;
    alu_op(5'd7, 32'h0000_0055);
    step();
    idle_in();
    expect_wr("waw_pipe", 1'b1, 5'd7, 32'h0000_0055);
    step();
    check("waw_dropped_en", bus.reg_write_en, 1'b0);
    check("waw_ready", bus.late_ready, 1'b1);
    step();
    check("waw_quiet_en", bus.reg_write_en, 1'b0);

    // Reset while FORCE with a late entry buffered
    bus.late_valid = 1'b1;
    bus.late_rd    = 5'd10;
    bus.late_data  = 32'h0000_CCCC;
    alu_op(5'd2, 32'h300);
    step();
    bus.late_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("rstmid_stall_pre", bus.wb_stall_req, 1'b1);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    expect_wr("rstmid", 1'b0, 5'd0, 32'h0);
    check("rstmid_ready", bus.late_ready, 1'b1);
    check("rstmid_stall", bus.wb_stall_req, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    check("rstpost_en_a", bus.reg_write_en, 1'b0);
    step();
    check("rstpost_en_b", bus.reg_write_en, 1'b0);
    check("rstpost_ready", bus.late_ready, 1'b1);
    check("rstpost_stall", bus.wb_stall_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
